store_monitor: RTL and testbench

Synthesizable store-bus monitor sitting directly downstream of the single-cycle ARM `top`; it consumes the processor's data-memory write port (`MemWrite`, `DataAdr`, `WriteData`). It decides pass/fail from store addresses and logs every accepted store into a small first-word-fall-through FIFO for later readout. It lets the same pass/fail check run in the bench or on hardware.

---
 rtl/store_mon_pkg.sv | 19 +
 rtl/store_fifo.sv | 80 ++++++++
 rtl/store_monitor.sv | 132 +++++++++++++
 tb/tb_store_monitor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/store_mon_pkg.sv
// Shared types for the store-bus monitor: run state, fail codes, log entry.
package store_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } mon_state_e;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_ADDR    = 2'd1;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

endpackage

// File: rtl/store_fifo.sv
// First-word-fall-through log FIFO. Head entry is presented combinationally
// from the storage registers; outputs read as zero while empty. A push into a
// full FIFO succeeds only when a pop happens in the same cycle, otherwise it
// is dropped and flagged on 'drop'.
module store_fifo
  import store_mon_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  log_entry_t                 push_entry,
  input  logic                       pop,
  output logic                       head_valid,
  output log_entry_t                 head_entry,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  log_entry_t        mem_q [DEPTH];
  log_entry_t        mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full, empty, push_ok, pop_ok;

  // Next-state for storage, pointers and occupancy count.
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    drop    = push && !push_ok;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Head presentation; zeroed while empty so the read port is quiet.
  always_comb begin
    head_valid = !empty;
    head_entry = empty ? '0 : mem_q[rd_ptr_q];
    count      = count_q;
  end

  // Register storage and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/store_monitor.sv
// Store-bus monitor downstream of the single-cycle ARM core. Decides pass/fail
// from store addresses and logs every accepted store into a FWFT FIFO.
// Optional run-cycle timeout enabled by defining STORE_MON_TIMEOUT_EN.
module store_monitor
  import store_mon_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = 32'd196,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          MemWrite,
  input  logic [31:0]                   DataAdr,
  input  logic [31:0]                   WriteData,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [31:0]                   rd_addr,
  output logic [31:0]                   rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   store_count,
  output logic                          done,
  output logic                          pass,
  output logic [1:0]                    fail_code,
  output logic                          overflow
);

  mon_state_e  state_q, state_d;
  logic [1:0]  fail_code_q, fail_code_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] store_count_q, store_count_d;
  logic        overflow_q, overflow_d;
  logic        sample;
  logic        fifo_drop;
  log_entry_t  push_entry;
  log_entry_t  head_entry;

`ifdef STORE_MON_TIMEOUT_EN
  logic [31:0] run_cnt_q, run_cnt_d;
  logic        timeout_hit;
`else
  logic        timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

  store_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (sample),
    .push_entry (push_entry),
    .pop        (rd_en),
    .head_valid (rd_valid),
    .head_entry (head_entry),
    .count      (fifo_count),
    .drop       (fifo_drop)
  );

  // Run decision, counters and next values of the registered status outputs.
  always_comb begin
    sample     = MemWrite && (state_q == ST_RUN);
    push_entry = '{addr: DataAdr, data: WriteData};

    state_d     = state_q;
    fail_code_d = fail_code_q;

    if (sample) begin
      if (DataAdr == PASS_ADDR) begin
        state_d = ST_PASS;
      end else if (DataAdr != SCRATCH_ADDR) begin
        state_d     = ST_FAIL;
        fail_code_d = FAIL_ADDR;
      end
    end

`ifdef STORE_MON_TIMEOUT_EN
    // Timeout applies only when no store decided the run on this edge.
    run_cnt_d   = (state_q == ST_RUN) ? run_cnt_q + 32'd1 : run_cnt_q;
    timeout_hit = (state_q == ST_RUN) && (run_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    if (timeout_hit && (state_d == ST_RUN)) begin
      state_d     = ST_FAIL;
      fail_code_d = FAIL_TIMEOUT;
    end
`endif

    store_count_d = (sample && (store_count_q != '1)) ? store_count_q + 16'd1
                                                       : store_count_q;
    overflow_d    = overflow_q | fifo_drop;
    done_d        = (state_d != ST_RUN);
    pass_d        = (state_d == ST_PASS);
  end

  // Monitor state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      fail_code_q   <= FAIL_NONE;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      store_count_q <= '0;
      overflow_q    <= 1'b0;
`ifdef STORE_MON_TIMEOUT_EN
      run_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      fail_code_q   <= fail_code_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      store_count_q <= store_count_d;
      overflow_q    <= overflow_d;
`ifdef STORE_MON_TIMEOUT_EN
      run_cnt_q     <= run_cnt_d;
`endif
    end
  end

  // Drive ports from the flops and the FIFO head.
  always_comb begin
    done        = done_q;
    pass        = pass_q;
    fail_code   = fail_code_q;
    store_count = store_count_q;
    overflow    = overflow_q;
    rd_addr     = head_entry.addr;
    rd_data     = head_entry.data;
  end

endmodule

// File: tb/tb_store_monitor.sv
// Directed self-checking bench for store_monitor.
module tb_store_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        rd_en;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  fifo_count;
  logic [15:0] store_count;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  store_monitor #(
    .PASS_ADDR      (32'd196),
    .SCRATCH_ADDR   (32'd96),
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite    (MemWrite),
    .DataAdr     (DataAdr),
    .WriteData   (WriteData),
    .rd_en       (rd_en),
    .rd_valid    (rd_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .fifo_count  (fifo_count),
    .store_count (store_count),
    .done        (done),
    .pass        (pass),
    .fail_code   (fail_code),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock edge with the current inputs, then release strobes.
  task automatic step();
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    step();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_pass"},  32'(pass), 0);
    check({tag, "_fcode"}, 32'(fail_code), 0);
    check({tag, "_scnt"},  32'(store_count), 0);
    check({tag, "_fcnt"},  32'(fifo_count), 0);
    check({tag, "_valid"}, 32'(rd_valid), 0);
    check({tag, "_ovf"},   32'(overflow), 0);
    check({tag, "_raddr"}, rd_addr, 0);
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; rd_en = 1'b0;
    step(); step();
    reset = 1'b0;
    check_idle("rst");

    // Pass sequence: 96, 96, 196
    store(32'd96, 32'h11);
    check("p1_valid", 32'(rd_valid), 1);
    check("p1_head",  rd_addr, 96);
    store(32'd96, 32'h22);
    check("p2_done", 32'(done), 0);
    store(32'd196, 32'h33);
    check("p3_done",  32'(done), 1);
    check("p3_pass",  32'(pass), 1);
    check("p3_fcode", 32'(fail_code), 0);
    check("p3_scnt",  32'(store_count), 3);
    check("p3_fcnt",  32'(fifo_count), 3);
    check("pop0_addr", rd_addr, 96);
    check("pop0_data", rd_data, 32'h11);
    pop();
    check("pop1_addr", rd_addr, 96);
    check("pop1_data", rd_data, 32'h22);
    pop();
    check("pop2_addr", rd_addr, 196);
    check("pop2_data", rd_data, 32'h33);
    pop();
    check("pop3_valid", 32'(rd_valid), 0);
    check("pop3_fcnt",  32'(fifo_count), 0);
    pop();
    check("popempty_fcnt", 32'(fifo_count), 0);

    // Bad address, then ignored store
    do_reset();
    store(32'd100, 32'h5);
    check("bad_done",  32'(done), 1);
    check("bad_pass",  32'(pass), 0);
    check("bad_fcode", 32'(fail_code), 1);
    store(32'd196, 32'h6);
    check("bad_scnt", 32'(store_count), 1);
    check("bad_fcnt", 32'(fifo_count), 1);
    check("bad_pass2", 32'(pass), 0);

    // Overflow: ten scratch stores without pops
    do_reset();
    for (int i = 0; i < 10; i++) store(32'd96, 32'(i));
    check("ovf_fcnt", 32'(fifo_count), 8);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_scnt", 32'(store_count), 10);
    check("ovf_done", 32'(done), 0);
    check("ovf_head", rd_data, 0);
    rd_en = 1'b1;
    store(32'd96, 32'd99);
    check("pp_fcnt", 32'(fifo_count), 8);
    check("pp_head", rd_data, 1);
    check("pp_scnt", 32'(store_count), 11);
    for (int i = 0; i < 7; i++) pop();
    check("pp_tail", rd_data, 32'd99);

    // Simultaneous push and pop on an empty FIFO: push only
    do_reset();
    rd_en = 1'b1;
    store(32'd96, 32'h77);
    check("ep_fcnt", 32'(fifo_count), 1);
    check("ep_data", rd_data, 32'h77);

`ifdef STORE_MON_TIMEOUT_EN
    do_reset();
    for (int i = 0; i < 15; i++) step();
    check("to15_done", 32'(done), 0);
    step();
    check("to16_done",  32'(done), 1);
    check("to16_fcode", 32'(fail_code), 2);
    check("to16_pass",  32'(pass), 0);
    do_reset();
    for (int i = 0; i < 15; i++) step();
    store(32'd196, 32'h1);
    check("tow_pass",  32'(pass), 1);
    check("tow_fcode", 32'(fail_code), 0);
`else
    do_reset();
    for (int i = 0; i < 40; i++) step();
    check("noto_done",  32'(done), 0);
    check("noto_fcode", 32'(fail_code), 0);
`endif

    // Reset from PASS with 3 entries; store held during reset not logged
    do_reset();
    store(32'd96, 32'h1);
    store(32'd96, 32'h2);
    store(32'd196, 32'h3);
    check("rp_pass", 32'(pass), 1);
    check("rp_fcnt", 32'(fifo_count), 3);
    reset = 1'b1; MemWrite = 1'b1; DataAdr = 32'd196; WriteData = 32'h9;
    @(posedge clk); #1;
    check_idle("rp");
    reset = 1'b0; MemWrite = 1'b0;
    step();
    check("rp2_fcnt", 32'(fifo_count), 0);
    check("rp2_done", 32'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
